cuckoo_l2_update_ctrl: RTL and testbench

Runtime table-update controller for the two-level Cuckoo payload lookup. It accepts host write commands for the L1 index RAM (ram_l2 class) or the L2 entry RAM (ram_t3_l2 class), in either the case or the nocase instance. To keep lookups coherent it freezes the lookup pipeline, lets it drain, issues a single write pulse, then guarantees a lookup window before the next update. It sits between the host register interface and the Cuckoo_L2 datapath: its pipe_enable drives the datapath enable, and its write ports drive the RAM write sides.

---
 rtl/cuckoo_l2_pkg.sv | 27 ++
 rtl/cuckoo_l2_update_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_cuckoo_l2_update_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/cuckoo_l2_pkg.sv
// ----------------------------------------------------------------------------
// cuckoo_l2_pkg
// Shared definitions for the Cuckoo_L2 runtime table-update controller:
//   - state_t       : update FSM state encoding
//   - TBL_L1/TBL_L2 : values of the table-select bit on the host command
//   - L1_AW, L1_DW  : default L1 index RAM address/data widths
//                     (the address includes the T1/T2 bank bit)
//   - L2_AW, L2_DW  : default L2 entry RAM address/data widths
// ----------------------------------------------------------------------------
package cuckoo_l2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_WRITE = 2'd2,
        ST_GUARD = 2'd3
    } state_t;

    localparam logic TBL_L1 = 1'b0;
    localparam logic TBL_L2 = 1'b1;

    localparam int L1_AW = 11;
    localparam int L1_DW = 9;
    localparam int L2_AW = 9;
    localparam int L2_DW = 18;

endpackage : cuckoo_l2_pkg

// File: rtl/cuckoo_l2_update_ctrl.sv
// ----------------------------------------------------------------------------
// cuckoo_l2_update_ctrl
// Runtime table-update controller for the two-level Cuckoo payload lookup.
// A host write command is latched, the lookup pipeline is frozen for
// DRAIN_CYCLES cycles so in-flight lookups finish, one write strobe is
// issued, and then MIN_GAP lookup cycles are guaranteed before the next
// command can be taken.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   upd_valid/ready    host command handshake
//   upd_table          0 = L1 index RAM, 1 = L2 entry RAM
//   upd_nocase         0 = case instance, 1 = nocase instance
//   upd_addr, upd_data command address / data (L1 writes use low L1_DW bits)
//   pipe_enable        enable to the lookup datapath
//   l1_we*, l1_addr, l1_din   L1 index RAM write side (address/data shared)
//   l2_we*, l2_addr, l2_din   L2 entry RAM write side (address/data shared)
//   upd_err            one-cycle pulse: L2 command address out of range
//   upd_count          completed writes, saturating
// ----------------------------------------------------------------------------
module cuckoo_l2_update_ctrl
    import cuckoo_l2_pkg::*;
#(
    parameter int L1_AW        = cuckoo_l2_pkg::L1_AW,
    parameter int L1_DW        = cuckoo_l2_pkg::L1_DW,
    parameter int L2_AW        = cuckoo_l2_pkg::L2_AW,
    parameter int L2_DW        = cuckoo_l2_pkg::L2_DW,
    parameter int DRAIN_CYCLES = 3,
    parameter int MIN_GAP      = 4
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             upd_valid,
    output logic             upd_ready,
    input  logic             upd_table,
    input  logic             upd_nocase,
    input  logic [L1_AW-1:0] upd_addr,
    input  logic [L2_DW-1:0] upd_data,

    output logic             pipe_enable,

    output logic             l1_we,
    output logic             l1_we_nocase,
    output logic [L1_AW-1:0] l1_addr,
    output logic [L1_DW-1:0] l1_din,

    output logic             l2_we,
    output logic             l2_we_nocase,
    output logic [L2_AW-1:0] l2_addr,
    output logic [L2_DW-1:0] l2_din,

    output logic             upd_err,
    output logic [15:0]      upd_count
);

    // One down-counter serves both STALL and GUARD, so size it for the longer.
    localparam int CNT_MAX = (DRAIN_CYCLES > MIN_GAP) ? DRAIN_CYCLES : MIN_GAP;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_zero;
    logic               accept;
    logic               enter_write;
    logic               cmd_in_range;

    // Command latch
    logic               cmd_table;
    logic               cmd_nocase;
    logic [L1_AW-1:0]   cmd_addr;
    logic [L2_DW-1:0]   cmd_data;

    assign accept      = upd_valid && upd_ready;
    assign cnt_zero    = (cnt == '0);
    assign enter_write = (state == ST_STALL) && cnt_zero;

    // L2 commands must fit the smaller L2 address space; L1 commands always fit.
    assign cmd_in_range = (cmd_table == TBL_L1) ||
                          (cmd_addr[L1_AW-1:L2_AW] == '0);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept)   state_next = ST_STALL;
            ST_STALL: if (cnt_zero) state_next = ST_WRITE;
            ST_WRITE:               state_next = ST_GUARD;
            ST_GUARD: if (cnt_zero) state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs decoded from state
    // ------------------------------------------------------------------------
    always_comb begin
        upd_ready   = 1'b0;
        pipe_enable = 1'b1;
        case (state)
            ST_IDLE: begin
                upd_ready   = 1'b1;
                pipe_enable = 1'b1;
            end
            ST_STALL, ST_WRITE: begin
                upd_ready   = 1'b0;
                pipe_enable = 1'b0;
            end
            ST_GUARD: begin
                upd_ready   = 1'b0;
                pipe_enable = 1'b1;
            end
            default: begin
                upd_ready   = 1'b0;
                pipe_enable = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Shared STALL/GUARD down-counter. Loaded with N-1 so the state it guards
    // lasts exactly N cycles (it leaves on the cycle the counter reads zero).
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            case (state)
                ST_IDLE:  if (accept)    cnt <= CNT_W'(DRAIN_CYCLES - 1);
                ST_STALL: if (!cnt_zero) cnt <= cnt - 1'b1;
                ST_WRITE:                cnt <= CNT_W'(MIN_GAP - 1);
                ST_GUARD: if (!cnt_zero) cnt <= cnt - 1'b1;
                default:                 cnt <= '0;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Command latch: captured on acceptance, held until the write slot.
    // ------------------------------------------------------------------------
    // NOTE: the latch is ordinary flops rather than a RAM, so it is cleared on
    // reset; a command interrupted by reset must not survive into the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_table  <= TBL_L1;
            cmd_nocase <= 1'b0;
            cmd_addr   <= '0;
            cmd_data   <= '0;
        end else if (accept) begin
            cmd_table  <= upd_table;
            cmd_nocase <= upd_nocase;
            cmd_addr   <= upd_addr;
            cmd_data   <= upd_data;
        end
    end

    // ------------------------------------------------------------------------
    // Write ports. Strobes, address and data are registered on the edge that
    // enters WRITE, so all of them are valid together for that one cycle.
    // Address/data hold their last value outside the slot.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            l1_we        <= 1'b0;
            l1_we_nocase <= 1'b0;
            l2_we        <= 1'b0;
            l2_we_nocase <= 1'b0;
            l1_addr      <= '0;
            l1_din       <= '0;
            l2_addr      <= '0;
            l2_din       <= '0;
            upd_err      <= 1'b0;
        end else begin
            l1_we        <= 1'b0;
            l1_we_nocase <= 1'b0;
            l2_we        <= 1'b0;
            l2_we_nocase <= 1'b0;
            upd_err      <= 1'b0;
            if (enter_write) begin
                if (!cmd_in_range) begin
                    upd_err <= 1'b1;
                end else if (cmd_table == TBL_L1) begin
                    l1_we        <= !cmd_nocase;
                    l1_we_nocase <= cmd_nocase;
                    l1_addr      <= cmd_addr;
                    l1_din       <= cmd_data[L1_DW-1:0];
                end else begin
                    l2_we        <= !cmd_nocase;
                    l2_we_nocase <= cmd_nocase;
                    l2_addr      <= cmd_addr[L2_AW-1:0];
                    l2_din       <= cmd_data;
                end
            end
        end
    end

    // Completed-write counter: bumps the cycle after a strobe, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            upd_count <= '0;
        end else if ((l1_we || l1_we_nocase || l2_we || l2_we_nocase) &&
                     (upd_count != 16'hFFFF)) begin
            upd_count <= upd_count + 16'd1;
        end
    end

endmodule : cuckoo_l2_update_ctrl

// File: tb/tb_cuckoo_l2_update_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cuckoo_l2_update_ctrl
// Directed bench for the Cuckoo_L2 update controller. Each command pushes its
// expected write (strobe, address, data, error) onto a scoreboard queue; a
// negedge monitor pops and compares whenever the DUT shows write activity.
// The main sequence checks handshake/enable timing cycle by cycle.
// ----------------------------------------------------------------------------
module tb_cuckoo_l2_update_ctrl;
    import cuckoo_l2_pkg::*;

    typedef struct {
        logic [3:0]       we;     // {l1_we, l1_we_nocase, l2_we, l2_we_nocase}
        logic             err;
        logic [L1_AW-1:0] addr;   // zero-extended for L2 targets
        logic [L2_DW-1:0] data;   // zero-extended for L1 targets
    } exp_t;

    logic             clk;
    logic             rst;
    logic             upd_valid;
    logic             upd_ready;
    logic             upd_table;
    logic             upd_nocase;
    logic [L1_AW-1:0] upd_addr;
    logic [L2_DW-1:0] upd_data;
    logic             pipe_enable;
    logic             l1_we;
    logic             l1_we_nocase;
    logic [L1_AW-1:0] l1_addr;
    logic [L1_DW-1:0] l1_din;
    logic             l2_we;
    logic             l2_we_nocase;
    logic [L2_AW-1:0] l2_addr;
    logic [L2_DW-1:0] l2_din;
    logic             upd_err;
    logic [15:0]      upd_count;

    logic [3:0]       we_vec;
    assign we_vec = {l1_we, l1_we_nocase, l2_we, l2_we_nocase};

    exp_t sb[$];
    int   errors      = 0;
    int   checks      = 0;
    int   model_count = 0;

    cuckoo_l2_update_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .upd_valid    (upd_valid),
        .upd_ready    (upd_ready),
        .upd_table    (upd_table),
        .upd_nocase   (upd_nocase),
        .upd_addr     (upd_addr),
        .upd_data     (upd_data),
        .pipe_enable  (pipe_enable),
        .l1_we        (l1_we),
        .l1_we_nocase (l1_we_nocase),
        .l1_addr      (l1_addr),
        .l1_din       (l1_din),
        .l2_we        (l2_we),
        .l2_we_nocase (l2_we_nocase),
        .l2_addr      (l2_addr),
        .l2_din       (l2_din),
        .upd_err      (upd_err),
        .upd_count    (upd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic t, input logic n,
                         input logic [L1_AW-1:0] a, input logic [L2_DW-1:0] d);
        upd_valid  = v;
        upd_table  = t;
        upd_nocase = n;
        upd_addr   = a;
        upd_data   = d;
    endtask

    // Expected write for a command, derived from the table/instance/range rules.
    function automatic exp_t expect_cmd(input logic t, input logic n,
                                        input logic [L1_AW-1:0] a,
                                        input logic [L2_DW-1:0] d);
        exp_t e;
        e.err  = t && (a[L1_AW-1:L2_AW] != '0);
        e.we   = 4'b0000;
        if (!e.err) begin
            case ({t, n})
                2'b00:   e.we = 4'b1000;
                2'b01:   e.we = 4'b0100;
                2'b10:   e.we = 4'b0010;
                default: e.we = 4'b0001;
            endcase
        end
        e.addr = t ? {{(L1_AW-L2_AW){1'b0}}, a[L2_AW-1:0]} : a;
        e.data = t ? d : {{(L2_DW-L1_DW){1'b0}}, d[L1_DW-1:0]};
        return e;
    endfunction

    // Called at a negedge in an IDLE cycle with the command already driven.
    // After the accepting edge T the next command (or junk, valid low) is
    // driven; returns at the negedge of cycle T+9.
    task automatic run_cmd(input string tag,
                           input logic t, input logic n,
                           input logic [L1_AW-1:0] a, input logic [L2_DW-1:0] d,
                           input logic nv, input logic nt, input logic nn,
                           input logic [L1_AW-1:0] na, input logic [L2_DW-1:0] nd);
        exp_t e;
        check({tag, "_ready_pre"}, upd_ready, 1'b1);
        e = expect_cmd(t, n, a, d);
        sb.push_back(e);
        if (!e.err) model_count++;
        @(posedge clk);
        #1;
        drive(nv, nt, nn, na, nd);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            check($sformatf("%s_pipe_en_c%0d", tag, k), pipe_enable, (k > 4));
            check($sformatf("%s_ready_c%0d", tag, k), upd_ready, (k == 9));
            check($sformatf("%s_wslot_c%0d", tag, k),
                  (we_vec != 4'b0000) || upd_err, (k == 4));
        end
        check({tag, "_count"}, upd_count, model_count);
    endtask

    // Scoreboard monitor: any strobe or error pulse consumes one expectation.
    always @(negedge clk) begin
        if (!rst && ((we_vec != 4'b0000) || upd_err)) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_write", sb.size(), 1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_strobes", we_vec, e.we);
                check("sb_err", upd_err, e.err);
                if (e.we[3] || e.we[2]) begin
                    check("sb_l1_addr", l1_addr, e.addr);
                    check("sb_l1_din", l1_din, e.data);
                end else if (e.we[1] || e.we[0]) begin
                    check("sb_l2_addr", l2_addr, e.addr);
                    check("sb_l2_din", l2_din, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: reset state, then idle
        @(negedge clk);
        check("rst_l1_addr", l1_addr, 0);
        check("rst_l1_din", l1_din, 0);
        check("rst_l2_addr", l2_addr, 0);
        check("rst_l2_din", l2_din, 0);
        for (int i = 0; i < 10; i++) begin
            check("idle_ready", upd_ready, 1'b1);
            check("idle_pipe_en", pipe_enable, 1'b1);
            check("idle_strobes", we_vec, 4'b0000);
            check("idle_err", upd_err, 1'b0);
            check("idle_count", upd_count, 0);
            @(negedge clk);
        end

        // 2: L1 case write; upper data bits must be ignored
        drive(1'b1, 1'b0, 1'b0, 11'h405, 18'h3F1A3);
        run_cmd("l1_case", 1'b0, 1'b0, 11'h405, 18'h3F1A3,
                1'b0, 1'b1, 1'b1, 11'h7AA, 18'h15555);

        // 3: L2 nocase write
        drive(1'b1, 1'b1, 1'b1, 11'h0FF, 18'h2ABCD);
        run_cmd("l2_nocase", 1'b1, 1'b1, 11'h0FF, 18'h2ABCD,
                1'b0, 1'b0, 1'b0, 11'h000, 18'h00000);

        // 4: L2 address out of range -> error pulse, no strobe, no count
        drive(1'b1, 1'b1, 1'b0, 11'h600, 18'h12345);
        run_cmd("l2_range", 1'b1, 1'b0, 11'h600, 18'h12345,
                1'b0, 1'b0, 1'b0, 11'h000, 18'h00000);

        // 5: valid held across three commands, accepted every 9 cycles
        drive(1'b1, 1'b0, 1'b1, 11'h7FF, 18'h00155);
        run_cmd("b2b_0", 1'b0, 1'b1, 11'h7FF, 18'h00155,
                1'b1, 1'b1, 1'b0, 11'h1FF, 18'h3FFFF);
        run_cmd("b2b_1", 1'b1, 1'b0, 11'h1FF, 18'h3FFFF,
                1'b1, 1'b1, 1'b1, 11'h000, 18'h00001);
        run_cmd("b2b_2", 1'b1, 1'b1, 11'h000, 18'h00001,
                1'b0, 1'b0, 1'b0, 11'h000, 18'h00000);
        check("sb_drained_pre_rst", sb.size(), 0);

        // 6: reset during STALL drops the pending write
        drive(1'b1, 1'b0, 1'b0, 11'h123, 18'h00045);
        check("rst_mid_ready_pre", upd_ready, 1'b1);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("rst_mid_stalled", pipe_enable, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_count = 0;
        for (int k = 3; k <= 7; k++) begin
            @(negedge clk);
            check($sformatf("rst_mid_ready_c%0d", k), upd_ready, 1'b1);
            check($sformatf("rst_mid_pipe_en_c%0d", k), pipe_enable, 1'b1);
            check($sformatf("rst_mid_strobes_c%0d", k), we_vec, 4'b0000);
            check($sformatf("rst_mid_count_c%0d", k), upd_count, model_count);
        end
        check("sb_drained_end", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_cuckoo_l2_update_ctrl
